// File: rtl/cv32e40p_apu_core_pkg.sv
// ============================================================================
// Module      : cv32e40p_apu_core_pkg
// Description : Shared types for the APU dispatcher: latency classes and the
//               tag recorded for every granted APU operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40p_apu_core_pkg;

  // Register-file write-address width carried in every tag.
  localparam int unsigned APU_WADDR_W = 6;

  // Latency class of an APU operation (2'b11 is folded into MULTI).
  typedef enum logic [1:0] {
    APU_LAT_SINGLE = 2'b00,
    APU_LAT_TWO    = 2'b01,
    APU_LAT_MULTI  = 2'b10
  } apu_lat_e;

  // One in-flight operation: where its result goes and how it is written back.
  typedef struct packed {
    logic [APU_WADDR_W-1:0] waddr;
    apu_lat_e               lat;
  } apu_tag_t;

  // Map the raw 2-bit latency field onto a legal class; reserved behaves as multicycle.
  function automatic apu_lat_e apu_norm_lat(input logic [1:0] lat);
    apu_lat_e res;
    case (lat)
      2'b00:   res = APU_LAT_SINGLE;
      2'b01:   res = APU_LAT_TWO;
      default: res = APU_LAT_MULTI;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40p_apu_dispatcher_if.sv
// ============================================================================
// Module      : cv32e40p_apu_dispatcher_if
// Description : Request/grant/result-valid handshake between the dispatcher
//               and the shared APU interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv32e40p_apu_dispatcher_if;

  logic apu_req_o;
  logic apu_gnt_i;
  logic apu_rvalid_i;

  // Dispatcher side: issues requests, observes grant and in-order result valid.
  modport master (
    output apu_req_o,
    input  apu_gnt_i,
    input  apu_rvalid_i
  );

  // APU / interconnect side.
  modport slave (
    input  apu_req_o,
    output apu_gnt_i,
    output apu_rvalid_i
  );

endinterface

`default_nettype wire

// File: rtl/cv32e40p_apu_dispatcher_tag_fifo.sv
// ============================================================================
// Module      : cv32e40p_apu_tag_fifo
// Description : In-order tag queue of granted APU ops. Exposes every entry
//               with its valid bit so the dispatcher can check hazards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_apu_tag_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 push_i,
  input  wire apu_tag_t             tag_i,
  input  wire logic                 pop_i,
  output apu_tag_t                  head_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [DEPTH-1:0]          entry_valid_o,
  output apu_tag_t [DEPTH-1:0]      entry_tag_o,
  output logic                      two_cycle_pending_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full_count = DEPTH[PTR_W:0];

  apu_tag_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]     r_valid;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [PTR_W:0]       r_count;

  // Pointer, count and per-entry valid update; a push into the slot being popped wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (pop_i) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      if (push_i) begin
        r_mem[r_wptr]   <= tag_i;
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= r_wptr + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags and the pending two-cycle reservation of the LSU port.
  always_comb begin
    head_o              = r_mem[r_rptr];
    empty_o             = (r_count == '0);
    full_o              = (r_count == c_full_count);
    entry_valid_o       = r_valid;
    entry_tag_o         = r_mem;
    two_cycle_pending_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_valid[i] && (r_mem[i].lat == APU_LAT_TWO)) begin
        two_cycle_pending_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40p_apu_dispatcher.sv
// ============================================================================
// Module      : cv32e40p_apu_dispatcher
// Description : EX-stage issue/tracking controller for the shared APU. Drives
//               req/gnt, tracks granted ops in order, flags RAW/WAW hazards
//               and retires results on apu_rvalid_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_apu_dispatcher
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  // Must equal APU_WADDR_W, the width stored in each tag.
  parameter int unsigned WADDR_W = APU_WADDR_W
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   enable_i,
  input  wire logic [1:0]             apu_lat_i,
  input  wire logic [WADDR_W-1:0]     apu_waddr_i,
  input  wire logic [3*WADDR_W-1:0]   read_regs_i,
  input  wire logic [2:0]             read_regs_valid_i,
  input  wire logic [2*WADDR_W-1:0]   write_regs_i,
  input  wire logic [1:0]             write_regs_valid_i,
  cv32e40p_apu_dispatcher_if.master   apu_if,
  output logic                        valid_o,
  output logic [WADDR_W-1:0]          waddr_o,
  output logic                        singlecycle_o,
  output logic                        multicycle_o,
  output logic                        active_o,
  output logic                        stall_o,
  output logic                        read_dep_o,
  output logic                        write_dep_o,
  output logic                        ready_wb_o,
  output logic                        perf_type_o,
  output logic                        perf_cont_o,
  output logic                        perf_wb_o
);

  apu_tag_t             w_head;
  apu_tag_t             w_in_tag;
  apu_tag_t             w_ret_tag;
  apu_tag_t [DEPTH-1:0] w_entry_tag;
  logic [DEPTH-1:0]     w_entry_valid;
  logic                 w_empty;
  logic                 w_full_raw;
  logic                 w_full;
  logic                 w_two_pending;
  logic                 w_req;
  logic                 w_push;
  logic                 w_queue_pop;
  logic                 w_bypass;
  logic                 w_fifo_push;
  logic                 w_read_dep;
  logic                 w_write_dep;

  cv32e40p_apu_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk                 (clk),
    .rst_n               (rst_n),
    .push_i              (w_fifo_push),
    .tag_i               (w_in_tag),
    .pop_i               (w_queue_pop),
    .head_o              (w_head),
    .empty_o             (w_empty),
    .full_o              (w_full_raw),
    .entry_valid_o       (w_entry_valid),
    .entry_tag_o         (w_entry_tag),
    .two_cycle_pending_o (w_two_pending)
  );

  // RAW/WAW check of the EX op against every valid tag, including one popping now.
  always_comb begin
    w_read_dep  = 1'b0;
    w_write_dep = 1'b0;
    for (int e = 0; e < int'(DEPTH); e++) begin
      for (int r = 0; r < 3; r++) begin
        if (w_entry_valid[e] && read_regs_valid_i[r] &&
            (read_regs_i[r*WADDR_W +: WADDR_W] == w_entry_tag[e].waddr)) begin
          w_read_dep = 1'b1;
        end
      end
      for (int w = 0; w < 2; w++) begin
        if (w_entry_valid[e] && write_regs_valid_i[w] &&
            (write_regs_i[w*WADDR_W +: WADDR_W] == w_entry_tag[e].waddr)) begin
          w_write_dep = 1'b1;
        end
      end
    end
    w_read_dep  = w_read_dep  & enable_i;
    w_write_dep = w_write_dep & enable_i;
  end

  // Issue, retire and bypass control plus all status/perf outputs.
  always_comb begin
    w_in_tag.waddr = apu_waddr_i;
    w_in_tag.lat   = apu_norm_lat(apu_lat_i);

    // A full queue is never empty, so its pop does not depend on this cycle's push;
    // this keeps full off the req -> push path and avoids a combinational loop.
    w_full      = w_full_raw & ~apu_if.apu_rvalid_i;
    w_req       = enable_i & ~w_read_dep & ~w_write_dep & ~w_full;
    w_push      = w_req & apu_if.apu_gnt_i;
    w_queue_pop = apu_if.apu_rvalid_i & ~w_empty;
    // Zero-latency APU: result arrives with the grant, nothing is enqueued.
    w_bypass    = apu_if.apu_rvalid_i & w_empty & w_push;
    w_fifo_push = w_push & ~w_bypass;

    w_ret_tag     = w_empty ? w_in_tag : w_head;
    valid_o       = w_queue_pop | w_bypass;
    waddr_o       = valid_o ? w_ret_tag.waddr : '0;
    singlecycle_o = valid_o & (w_ret_tag.lat == APU_LAT_SINGLE);
    multicycle_o  = valid_o & (w_ret_tag.lat == APU_LAT_MULTI);

    apu_if.apu_req_o = w_req;
    read_dep_o       = w_read_dep;
    write_dep_o      = w_write_dep;
    active_o         = ~w_empty | w_req;
    stall_o          = enable_i & (w_read_dep | w_write_dep | w_full |
                                   (w_req & ~apu_if.apu_gnt_i));
    ready_wb_o       = ~w_two_pending;
    perf_type_o      = enable_i & (w_read_dep | w_write_dep);
    perf_cont_o      = w_req & ~apu_if.apu_gnt_i;
    perf_wb_o        = enable_i & w_full;
  end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_apu_dispatcher.sv
// ============================================================================
// Module      : tb_cv32e40p_apu_dispatcher
// Description : Directed self-checking bench for the APU dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_apu_dispatcher;

  localparam int unsigned W = 6;

  logic           clk;
  logic           rst_n;
  logic           enable_i;
  logic [1:0]     apu_lat_i;
  logic [W-1:0]   apu_waddr_i;
  logic [3*W-1:0] read_regs_i;
  logic [2:0]     read_regs_valid_i;
  logic [2*W-1:0] write_regs_i;
  logic [1:0]     write_regs_valid_i;
  logic           valid_o;
  logic [W-1:0]   waddr_o;
  logic           singlecycle_o;
  logic           multicycle_o;
  logic           active_o;
  logic           stall_o;
  logic           read_dep_o;
  logic           write_dep_o;
  logic           ready_wb_o;
  logic           perf_type_o;
  logic           perf_cont_o;
  logic           perf_wb_o;

  int n_tests;
  int n_fail;

  cv32e40p_apu_dispatcher_if apu_if ();

  cv32e40p_apu_dispatcher #(
    .DEPTH   (2),
    .WADDR_W (W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable_i           (enable_i),
    .apu_lat_i          (apu_lat_i),
    .apu_waddr_i        (apu_waddr_i),
    .read_regs_i        (read_regs_i),
    .read_regs_valid_i  (read_regs_valid_i),
    .write_regs_i       (write_regs_i),
    .write_regs_valid_i (write_regs_valid_i),
    .apu_if             (apu_if),
    .valid_o            (valid_o),
    .waddr_o            (waddr_o),
    .singlecycle_o      (singlecycle_o),
    .multicycle_o       (multicycle_o),
    .active_o           (active_o),
    .stall_o            (stall_o),
    .read_dep_o         (read_dep_o),
    .write_dep_o        (write_dep_o),
    .ready_wb_o         (ready_wb_o),
    .perf_type_o        (perf_type_o),
    .perf_cont_o        (perf_cont_o),
    .perf_wb_o          (perf_wb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    enable_i            = 1'b0;
    apu_lat_i           = 2'b00;
    apu_waddr_i         = '0;
    read_regs_i         = '0;
    read_regs_valid_i   = '0;
    write_regs_i        = '0;
    write_regs_valid_i  = '0;
    apu_if.apu_gnt_i    = 1'b0;
    apu_if.apu_rvalid_i = 1'b0;
  endtask

  task automatic op(input logic [1:0] lat, input logic [W-1:0] wa,
                    input logic gnt, input logic rv);
    idle();
    enable_i            = 1'b1;
    apu_lat_i           = lat;
    apu_waddr_i         = wa;
    apu_if.apu_gnt_i    = gnt;
    apu_if.apu_rvalid_i = rv;
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are sampled at the falling edge.
  task automatic settle();
    #4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    n_tests++; if (apu_if.apu_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", apu_if.apu_req_o); end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    n_tests++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b exp 0", active_o); end
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    n_tests++; if (ready_wb_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_wb got %b exp 1", ready_wb_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    op(2'b00, 6'd5, 1'b1, 1'b1);
    settle();
    n_tests++; if (apu_if.apu_req_o !== 1'b1) begin n_fail++; $display("FAIL byp_req got %b exp 1", apu_if.apu_req_o); end
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL byp_valid got %b exp 1", valid_o); end
    n_tests++; if (waddr_o !== 6'd5) begin n_fail++; $display("FAIL byp_waddr got %0d exp 5", waddr_o); end
    n_tests++; if (singlecycle_o !== 1'b1) begin n_fail++; $display("FAIL byp_single got %b exp 1", singlecycle_o); end
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL byp_stall got %b exp 0", stall_o); end
    step();
    op(2'b11, 6'd21, 1'b1, 1'b1);
    settle();
    n_tests++; if (waddr_o !== 6'd21) begin n_fail++; $display("FAIL byp11_waddr got %0d exp 21", waddr_o); end
    n_tests++; if (multicycle_o !== 1'b1 || singlecycle_o !== 1'b0) begin n_fail++; $display("FAIL byp11_class got m%b s%b exp m1 s0", multicycle_o, singlecycle_o); end
    step();
    idle();
    settle();
    n_tests++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL byp_empty_active got %b exp 0", active_o); end
    step();
  endtask

  task automatic test_raw();
    op(2'b10, 6'd7, 1'b1, 1'b0);
    settle();
    n_tests++; if (apu_if.apu_req_o !== 1'b1) begin n_fail++; $display("FAIL raw_issue_req got %b exp 1", apu_if.apu_req_o); end
    step();
    op(2'b00, 6'd9, 1'b1, 1'b0);
    read_regs_i[W +: W] = 6'd7;
    read_regs_valid_i   = 3'b010;
    settle();
    n_tests++; if (read_dep_o !== 1'b1) begin n_fail++; $display("FAIL raw_dep got %b exp 1", read_dep_o); end
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall got %b exp 1", stall_o); end
    n_tests++; if (apu_if.apu_req_o !== 1'b0) begin n_fail++; $display("FAIL raw_req got %b exp 0", apu_if.apu_req_o); end
    n_tests++; if (perf_type_o !== 1'b1) begin n_fail++; $display("FAIL raw_perf_type got %b exp 1", perf_type_o); end
    n_tests++; if (write_dep_o !== 1'b0) begin n_fail++; $display("FAIL raw_no_waw got %b exp 0", write_dep_o); end
    step();
    apu_if.apu_rvalid_i = 1'b1;
    settle();
    n_tests++; if (read_dep_o !== 1'b1) begin n_fail++; $display("FAIL raw_pop_dep got %b exp 1", read_dep_o); end
    n_tests++; if (valid_o !== 1'b1 || waddr_o !== 6'd7) begin n_fail++; $display("FAIL raw_retire got v%b wa%0d exp v1 wa7", valid_o, waddr_o); end
    n_tests++; if (multicycle_o !== 1'b1) begin n_fail++; $display("FAIL raw_retire_multi got %b exp 1", multicycle_o); end
    step();
    apu_if.apu_rvalid_i = 1'b0;
    settle();
    n_tests++; if (read_dep_o !== 1'b0) begin n_fail++; $display("FAIL raw_clear_dep got %b exp 0", read_dep_o); end
    n_tests++; if (apu_if.apu_req_o !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_clear_req got r%b s%b exp r1 s0", apu_if.apu_req_o, stall_o); end
    step();
    idle();
    apu_if.apu_rvalid_i = 1'b1;
    settle();
    n_tests++; if (valid_o !== 1'b1 || waddr_o !== 6'd9 || singlecycle_o !== 1'b1) begin n_fail++; $display("FAIL raw_drain got v%b wa%0d s%b exp v1 wa9 s1", valid_o, waddr_o, singlecycle_o); end
    step();
    idle();
    settle();
    n_tests++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL raw_idle_active got %b exp 0", active_o); end
    step();
  endtask

  task automatic test_full();
    op(2'b10, 6'd3, 1'b1, 1'b0);
    step();
    op(2'b10, 6'd4, 1'b1, 1'b0);
    settle();
    n_tests++; if (perf_wb_o !== 1'b0 || apu_if.apu_req_o !== 1'b1) begin n_fail++; $display("FAIL full_second_issue got wb%b r%b exp wb0 r1", perf_wb_o, apu_if.apu_req_o); end
    step();
    op(2'b10, 6'd6, 1'b1, 1'b0);
    write_regs_i[W +: W] = 6'd4;
    write_regs_valid_i   = 2'b10;
    settle();
    n_tests++; if (perf_wb_o !== 1'b1) begin n_fail++; $display("FAIL full_perf_wb got %b exp 1", perf_wb_o); end
    n_tests++; if (stall_o !== 1'b1 || apu_if.apu_req_o !== 1'b0) begin n_fail++; $display("FAIL full_stall got s%b r%b exp s1 r0", stall_o, apu_if.apu_req_o); end
    n_tests++; if (write_dep_o !== 1'b1) begin n_fail++; $display("FAIL full_waw got %b exp 1", write_dep_o); end
    step();
    op(2'b10, 6'd6, 1'b1, 1'b1);
    settle();
    n_tests++; if (apu_if.apu_req_o !== 1'b1 || perf_wb_o !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_req got r%b wb%b exp r1 wb0", apu_if.apu_req_o, perf_wb_o); end
    n_tests++; if (valid_o !== 1'b1 || waddr_o !== 6'd3) begin n_fail++; $display("FAIL full_pushpop_retire got v%b wa%0d exp v1 wa3", valid_o, waddr_o); end
    step();
    op(2'b00, 6'd30, 1'b1, 1'b0);
    settle();
    n_tests++; if (perf_wb_o !== 1'b1) begin n_fail++; $display("FAIL full_count_held got %b exp 1", perf_wb_o); end
    step();
    idle();
    apu_if.apu_rvalid_i = 1'b1;
    settle();
    n_tests++; if (waddr_o !== 6'd4) begin n_fail++; $display("FAIL full_order1 got %0d exp 4", waddr_o); end
    step();
    settle();
    n_tests++; if (waddr_o !== 6'd6 || valid_o !== 1'b1) begin n_fail++; $display("FAIL full_order2 got v%b wa%0d exp v1 wa6", valid_o, waddr_o); end
    step();
    settle();
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL full_stray_rvalid got %b exp 0", valid_o); end
    step();
  endtask

  task automatic test_contention();
    for (int c = 0; c < 3; c++) begin
      op(2'b00, 6'd10, 1'b0, 1'b0);
      settle();
      n_tests++; if (apu_if.apu_req_o !== 1'b1 || perf_cont_o !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL cont_wait%0d got r%b c%b s%b exp r1 c1 s1", c, apu_if.apu_req_o, perf_cont_o, stall_o); end
      step();
    end
    op(2'b00, 6'd10, 1'b1, 1'b0);
    settle();
    n_tests++; if (stall_o !== 1'b0 || perf_cont_o !== 1'b0) begin n_fail++; $display("FAIL cont_grant got s%b c%b exp s0 c0", stall_o, perf_cont_o); end
    step();
    idle();
    settle();
    n_tests++; if (active_o !== 1'b1) begin n_fail++; $display("FAIL cont_pushed got %b exp 1", active_o); end
    step();
    apu_if.apu_rvalid_i = 1'b1;
    settle();
    n_tests++; if (valid_o !== 1'b1 || waddr_o !== 6'd10) begin n_fail++; $display("FAIL cont_retire got v%b wa%0d exp v1 wa10", valid_o, waddr_o); end
    step();
    idle();
    step();
  endtask

  task automatic test_two_cycle_reset();
    op(2'b01, 6'd11, 1'b1, 1'b0);
    settle();
    n_tests++; if (ready_wb_o !== 1'b1) begin n_fail++; $display("FAIL two_before got %b exp 1", ready_wb_o); end
    step();
    idle();
    settle();
    n_tests++; if (ready_wb_o !== 1'b0) begin n_fail++; $display("FAIL two_pending got %b exp 0", ready_wb_o); end
    step();
    apu_if.apu_rvalid_i = 1'b1;
    settle();
    n_tests++; if (ready_wb_o !== 1'b0 || valid_o !== 1'b1 || waddr_o !== 6'd11) begin n_fail++; $display("FAIL two_retire got rw%b v%b wa%0d exp rw0 v1 wa11", ready_wb_o, valid_o, waddr_o); end
    n_tests++; if (singlecycle_o !== 1'b0 || multicycle_o !== 1'b0) begin n_fail++; $display("FAIL two_port got s%b m%b exp s0 m0", singlecycle_o, multicycle_o); end
    step();
    idle();
    settle();
    n_tests++; if (ready_wb_o !== 1'b1) begin n_fail++; $display("FAIL two_released got %b exp 1", ready_wb_o); end
    step();
    op(2'b01, 6'd12, 1'b1, 1'b0);
    step();
    op(2'b10, 6'd13, 1'b1, 1'b0);
    step();
    idle();
    settle();
    n_tests++; if (active_o !== 1'b1 || ready_wb_o !== 1'b0) begin n_fail++; $display("FAIL rst_inflight got a%b rw%b exp a1 rw0", active_o, ready_wb_o); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (active_o !== 1'b0 || ready_wb_o !== 1'b1) begin n_fail++; $display("FAIL rst_async got a%b rw%b exp a0 rw1", active_o, ready_wb_o); end
    #1;
    rst_n = 1'b1;
    step();
    apu_if.apu_rvalid_i = 1'b1;
    settle();
    n_tests++; if (valid_o !== 1'b0 || waddr_o !== 6'd0) begin n_fail++; $display("FAIL rst_late_rvalid got v%b wa%0d exp v0 wa0", valid_o, waddr_o); end
    step();
    idle();
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_bypass();
    test_raw();
    test_full();
    test_contention();
    test_two_cycle_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
